// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-strobed key matrix scan with per-key
// scan-based debounce and note events on a valid/ready handshake.
module keypad_matrix_scanner #(
  parameter int NUM_COLS       = 4,
  parameter int NUM_ROWS       = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int KEY_W          = $clog2(NUM_COLS*NUM_ROWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [NUM_COLS-1:0]          col_n,
  input  logic [NUM_ROWS-1:0]          row_n,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [KEY_W-1:0]             evt_key,
  output logic                         evt_press,
  output logic [NUM_COLS*NUM_ROWS-1:0] key_state
);
  localparam int NK  = NUM_COLS*NUM_ROWS;
  localparam int CW  = $clog2(DEBOUNCE_SCANS+1);
  localparam int CLW = $clog2(NUM_COLS);
  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SW  = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {SETTLE, SAMPLE, EVAL, HOLD} state_t;

  state_t              state;
  logic [NUM_ROWS-1:0] sync1, sync2, row_cap;
  logic [CLW-1:0]      col;
  logic [RW-1:0]       row_idx;
  logic [SW-1:0]       settle;
  logic [CW-1:0]       cnt [NK];

  logic [KEY_W-1:0] kidx;
  logic [CLW-1:0]   col_nx;
  logic [CW-1:0]    cnt_inc;
  logic             sample, last_row, qualify;

  assign kidx     = KEY_W'(int'(col) * NUM_ROWS + int'(row_idx));
  assign sample   = row_cap[row_idx];
  assign last_row = (int'(row_idx) == NUM_ROWS-1);
  assign col_nx   = (int'(col) == NUM_COLS-1) ? '0 : col + CLW'(1);
  assign cnt_inc  = cnt[kidx] + CW'(1);
  assign qualify  = (int'(cnt[kidx]) + 1 >= DEBOUNCE_SCANS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SETTLE;
      sync1     <= '1;
      sync2     <= '1;
      row_cap   <= '0;
      col       <= '0;
      row_idx   <= '0;
      settle    <= '0;
      col_n     <= '1;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_press <= 1'b0;
      key_state <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      sync1 <= row_n;
      sync2 <= sync1;
      // strobe follows the column register, held through HOLD
      col_n <= ~(NUM_COLS'(1) << col);
      unique case (state)
        SETTLE: begin
          settle <= settle + SW'(1);
          if (int'(settle) == SETTLE_CYCLES-1) begin
            settle <= '0;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          row_cap <= ~sync2;
          row_idx <= '0;
          state   <= EVAL;
        end
        EVAL: begin
          if (sample == key_state[kidx]) begin
            cnt[kidx] <= '0;
          end else if (!qualify) begin
            cnt[kidx] <= cnt_inc;
          end
          if (sample != key_state[kidx] && qualify) begin
            cnt[kidx]       <= '0;
            key_state[kidx] <= sample;
            evt_valid       <= 1'b1;
            evt_key         <= kidx;
            evt_press       <= sample;
            state           <= HOLD;
          end else if (last_row) begin
            col   <= col_nx;
            state <= SETTLE;
          end else begin
            row_idx <= row_idx + RW'(1);
          end
        end
        HOLD: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            if (last_row) begin
              col   <= col_nx;
              state <= SETTLE;
            end else begin
              row_idx <= row_idx + RW'(1);
              state   <= EVAL;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Drives the synth's key matrix and converts it into debounced note-on/note-off events. It strobes one active-low column at a time and samples the active-low row lines through an internal synchronizer. Each key is debounced across whole-matrix scans, and every qualified change is emitted as a single event on a valid/ready handshake to the voice-allocation logic. The block is the driving end of the button interface; it replaces per-pin debouncers for matrix-wired keys.

## Interface
- NUM_COLS, 4, matrix columns (driven outputs), ≥2
- NUM_ROWS, 4, matrix rows (sampled inputs), ≥1
- SETTLE_CYCLES, 16, cycles a column is driven before rows are sampled, ≥3 (covers 2-flop sync)
- DEBOUNCE_SCANS, 3, consecutive differing scans required to flip a key's stable state, ≥1
- KEY_W, $clog2(NUM_COLS*NUM_ROWS), event key index width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- col_n  out  NUM_COLS  column drive, exactly one bit low outside reset
- row_n  in  NUM_ROWS  raw row lines, pulled up; low = key pressed on driven column
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_key  out  KEY_W  key index = col*NUM_ROWS + row
- evt_press  out  1  1 = press (note-on), 0 = release (note-off)
- key_state  out  NUM_COLS*NUM_ROWS  debounced stable state, 1 = pressed

## Operation
- row_n passes through a 2-flop synchronizer and is inverted, so pressed = 1.
- Per key: a stable bit in key_state and a counter of width $clog2(DEBOUNCE_SCANS+1).
- The FSM walks columns 0..NUM_COLS-1 and wraps to 0. It has four states:
  - SETTLE: col_n drives the current column low; settle counter runs 0..SETTLE_CYCLES-1; at SETTLE_CYCLES-1 → SAMPLE.
  - SAMPLE: latch the synchronized row vector into row_cap; row_idx=0; → EVAL.
  - EVAL: for key k=(col,row_idx):
    - sample == stable → counter=0.
    - sample != stable and counter+1 < DEBOUNCE_SCANS → counter++.
    - sample != stable and counter+1 == DEBOUNCE_SCANS → flip key_state[k], counter=0, load evt_key=k and evt_press=new state, set evt_valid → HOLD.
    - No event: if row_idx == NUM_ROWS-1 → advance column and go to SETTLE, else row_idx++.
  - HOLD: evt_valid, evt_key, evt_press and col_n are held stable.
    - On evt_valid && evt_ready: clear evt_valid, then advance exactly as the no-event EVAL path in the same cycle.
- Scanning stalls completely while an event is unaccepted; no event is ever dropped or overwritten.
- Keys in one column that qualify in the same scan are emitted in ascending row order, one per handshake.
- No ghost/anti-ghost filtering; key_state reflects the raw matrix after debounce.
- Column advance wraps from NUM_COLS-1 to 0; the settle counter restarts at 0.

## Timing
- While rst is low:
  - col_n = all ones.
  - evt_valid=0, evt_key=0, evt_press=0, key_state=0.
  - All counters 0; FSM = SETTLE, column 0; synchronizer flops reset to 1 (released).
- First clk edge after rst deasserts: col_n = ...1110.
- Column period with no events: SETTLE_CYCLES + 1 + NUM_ROWS cycles (default 21); full scan is 84 cycles.
- Each event adds ≥1 cycle (HOLD), plus any evt_ready stall.
- key_state[k] updates on the EVAL edge; evt_valid rises on the same edge.
- Detection latency: the change is registered in the DEBOUNCE_SCANS-th consecutive scan that sees it.
- A 1..DEBOUNCE_SCANS-1 scan glitch produces no event and no key_state change.
- evt_ready may be high continuously; acceptance is combinational on evt_valid && evt_ready at a clk edge.
- Reset asserted mid-handshake: the pending event is discarded and all state returns to reset values; no event is replayed.

## Test plan
- Reset, no keys:
  - col_n=1111 during reset; after release the sequence is 1110, 1101, 1011, 0111, 1110, each column held 21 cycles.
  - evt_valid stays 0 for 10 scans.
- Press, then release, key (col1,row2):
  - Hold row_n[2] low while col_n[1] is low.
  - On scan 3: evt_valid=1, evt_key=6, evt_press=1, key_state[6]=1.
  - Release: after 3 scans, evt_key=6, evt_press=0.
- Bounce:
  - Press key 0 for 2 scans, release for 1 scan, then press steadily: exactly one press event, 3 scans after steady press begins.
  - A 2-scan glitch alone produces no event.
- Backpressure:
  - Keys 4 and 7 (col1, rows 0 and 3) pressed in the same scan, evt_ready=0 for 50 cycles.
  - evt_valid/evt_key=4/evt_press stay stable and col_n holds 1101.
  - Raising evt_ready emits 4, then 7, then scanning resumes.
- Reset mid-handshake:
  - Pull rst low while evt_valid=1: evt_valid=0 and key_state=0 immediately.
  - The key still pressed after release produces a fresh press event after 3 scans.
- Multi-column ordering:
  - Keys 15 and 1 pressed simultaneously: events arrive in scan order 1 then 15, each with evt_press=1.
